// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encodings, parity mode constants and parity helper
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  function automatic logic par_bit(input logic ones_odd, input int mode);
    return ones_odd ^ (mode == PAR_ODD);
  endfunction
endpackage

// File: rtl/uart_trx_cfg_if.sv
// uart_trx_cfg_if: word-level TX/RX handshake and error flags of the UART
interface uart_trx_cfg_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] tx_data, rx_data;
  logic tx_valid, tx_ready, tx_busy, rx_valid, rx_ready;
  logic parity_err, frame_err, overrun_err, err_clr;
  modport master (output tx_data, tx_valid, rx_ready, err_clr,
                  input tx_ready, tx_busy, rx_data, rx_valid, parity_err, frame_err, overrun_err);
  modport slave (input tx_data, tx_valid, rx_ready, err_clr,
                 output tx_ready, tx_busy, rx_data, rx_valid, parity_err, frame_err, overrun_err);
endinterface

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: free-running bit-period counter held at zero while load is high
module uart_baud_cnt #(parameter int CLKS_PER_BIT = 434) (
  input  logic clk,
  input  logic n_rst,
  input  logic load,
  output logic tick,
  output logic half
);
  localparam int W = $clog2(CLKS_PER_BIT);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) cnt <= '0;
    else cnt <= load || tick ? '0 : cnt + W'(1);
  assign tick = cnt == W'(CLKS_PER_BIT - 1);
  assign half = cnt == W'(CLKS_PER_BIT / 2 - 1);
endmodule

// File: rtl/uart_trx_cfg.sv
// uart_trx_cfg: configurable UART transmitter and receiver with parity and sticky error flags
module uart_trx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           n_rst,
  uart_trx_cfg_if.slave  bus,
  output logic           tx,
  input  logic           rx
);
  if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
      (PARITY_MODE != PAR_NONE && PARITY_MODE != PAR_EVEN && PARITY_MODE != PAR_ODD)) begin : g_bad_cfg
    $error("uart_trx_cfg: illegal parameter set");
  end
  localparam logic [3:0] LAST_D = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_S = 4'(STOP_BITS - 1);
  tx_state_t tx_st;
  rx_state_t rx_st;
  logic [DATA_BITS-1:0] tx_sh, rx_sh, rx_data;
  logic [3:0] tx_bit, rx_bit;
  logic tx_par, tx_ready, tx_busy, tx_tick, tx_half, rx_tick, rx_half;
  logic rx_m, rx_s, rx_d, rx_valid, parity_err, frame_err, overrun_err;
  logic rx_done, par_set, frame_set, ovr_set, unused_baud;
  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_baud (
    .clk(clk), .n_rst(n_rst), .load(tx_st == TX_IDLE), .tick(tx_tick), .half(tx_half));
  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_baud (
    .clk(clk), .n_rst(n_rst), .load(rx_st == RX_IDLE), .tick(rx_tick), .half(rx_half));
  assign unused_baud = tx_half ^ rx_tick;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      tx_st <= TX_IDLE;
      tx <= 1'b1;
      tx_ready <= 1'b0;
      tx_busy <= 1'b0;
      tx_sh <= '0;
      tx_par <= 1'b0;
      tx_bit <= '0;
    end else
      case (tx_st)
        TX_IDLE: if (bus.tx_valid && tx_ready) begin
          tx_st <= TX_START;
          tx <= 1'b0;
          tx_ready <= 1'b0;
          tx_busy <= 1'b1;
          tx_sh <= bus.tx_data;
          tx_par <= par_bit(^bus.tx_data, PARITY_MODE);
        end else tx_ready <= 1'b1;
        TX_START: if (tx_tick) begin
          tx_st <= TX_DATA;
          tx <= tx_sh[0];
          tx_sh <= tx_sh >> 1;
        end
        TX_DATA: if (tx_tick) begin
          tx_bit <= tx_bit == LAST_D ? '0 : tx_bit + 4'd1;
          tx_st <= tx_bit != LAST_D ? TX_DATA : PARITY_MODE == PAR_NONE ? TX_STOP : TX_PARITY;
          tx <= tx_bit != LAST_D ? tx_sh[0] : PARITY_MODE == PAR_NONE ? 1'b1 : tx_par;
          tx_sh <= tx_sh >> 1;
        end
        TX_PARITY: if (tx_tick) begin
          tx_st <= TX_STOP;
          tx <= 1'b1;
        end
        TX_STOP: if (tx_tick) begin
          tx_bit <= tx_bit == LAST_S ? '0 : tx_bit + 4'd1;
          if (tx_bit == LAST_S) begin
            tx_st <= TX_IDLE;
            tx_ready <= 1'b1;
            tx_busy <= 1'b0;
          end
        end
        default: tx_st <= TX_IDLE;
      endcase
  // every RX decision is taken on rx_s; rx_d only serves start-edge detection
  assign par_set = rx_st == RX_PARITY && rx_half && rx_s != par_bit(^rx_sh, PARITY_MODE);
  assign rx_done = rx_st == RX_STOP && rx_half && rx_s;
  assign frame_set = rx_st == RX_STOP && rx_half && !rx_s;
  assign ovr_set = rx_done && rx_valid && !bus.rx_ready;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      {rx_d, rx_s, rx_m} <= 3'b111;
      rx_st <= RX_IDLE;
      rx_bit <= '0;
      rx_sh <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      {rx_d, rx_s, rx_m} <= {rx_s, rx_m, rx};
      case (rx_st)
        RX_IDLE: rx_st <= rx_d && !rx_s ? RX_START : RX_IDLE;
        RX_START: if (rx_half) rx_st <= rx_s ? RX_IDLE : RX_DATA;
        RX_DATA: if (rx_half) begin
          rx_sh <= {rx_s, rx_sh[DATA_BITS-1:1]};
          rx_bit <= rx_bit == LAST_D ? '0 : rx_bit + 4'd1;
          if (rx_bit == LAST_D) rx_st <= PARITY_MODE == PAR_NONE ? RX_STOP : RX_PARITY;
        end
        RX_PARITY: if (rx_half) rx_st <= RX_STOP;
        RX_STOP: if (rx_half) rx_st <= RX_IDLE;
        default: rx_st <= RX_IDLE;
      endcase
      if (rx_done && (!rx_valid || bus.rx_ready)) rx_data <= rx_sh;
      rx_valid <= rx_done || (rx_valid && !bus.rx_ready);
      parity_err <= par_set || (parity_err && !bus.err_clr);
      frame_err <= frame_set || (frame_err && !bus.err_clr);
      overrun_err <= ovr_set || (overrun_err && !bus.err_clr);
    end
  assign bus.tx_ready = tx_ready;
  assign bus.tx_busy = tx_busy;
  assign bus.rx_data = rx_data;
  assign bus.rx_valid = rx_valid;
  assign bus.parity_err = parity_err;
  assign bus.frame_err = frame_err;
  assign bus.overrun_err = overrun_err;
endmodule

// File: tb/tb_uart_trx_cfg.sv
// tb_uart_trx_cfg: directed checks of two UART configurations (8E1 and 7O2, 4 clocks per bit)
module tb_uart_trx_cfg;
  logic clk = 1'b0;
  logic n_rst = 1'b1;
  logic tx_a, rx_a, tx_b, rx_b;
  logic rx_a_drv = 1'b1;
  logic loop_a = 1'b0;
  int total = 0;
  int bad = 0;
  logic [7:0] got_a[$];
  always #5 clk = ~clk;
  uart_trx_cfg_if #(.DATA_BITS(8)) a_if ();
  uart_trx_cfg_if #(.DATA_BITS(7)) b_if ();
  assign rx_a = loop_a ? tx_a : rx_a_drv;
  assign rx_b = tx_b;
  uart_trx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_a (
    .clk(clk), .n_rst(n_rst), .bus(a_if), .tx(tx_a), .rx(rx_a));
  uart_trx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) u_b (
    .clk(clk), .n_rst(n_rst), .bus(b_if), .tx(tx_b), .rx(rx_b));
  always @(negedge clk) if (a_if.rx_valid && a_if.rx_ready) got_a.push_back(a_if.rx_data);
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send_a(input logic [7:0] w);
    int n = 0;
    while (!a_if.tx_ready && n < 200) begin step(); n++; end
    chk("a_ready_wait", 32'(a_if.tx_ready), 1);
    a_if.tx_data = w;
    a_if.tx_valid = 1'b1;
    step();
    a_if.tx_valid = 1'b0;
  endtask
  task automatic send_b(input logic [6:0] w);
    int n = 0;
    while (!b_if.tx_ready && n < 200) begin step(); n++; end
    chk("b_ready_wait", 32'(b_if.tx_ready), 1);
    b_if.tx_data = w;
    b_if.tx_valid = 1'b1;
    step();
    b_if.tx_valid = 1'b0;
  endtask
  task automatic chk_frame(input string tag, input logic [10:0] f, input bit b);
    for (int k = 0; k < 11; k++)
      for (int j = 0; j < 4; j++) begin
        chk(tag, 32'(b ? tx_b : tx_a), 32'(f[k]));
        chk({tag, "_busy"}, 32'(b ? b_if.tx_busy : a_if.tx_busy), 1);
        step();
      end
    chk({tag, "_busy_end"}, 32'(b ? b_if.tx_busy : a_if.tx_busy), 0);
    chk({tag, "_ready_back"}, 32'(b ? b_if.tx_ready : a_if.tx_ready), 1);
    chk({tag, "_idle_line"}, 32'(b ? tx_b : tx_a), 1);
  endtask
  task automatic drive_a(input logic [10:0] bits, input logic hold, input int clr_at);
    for (int i = 0; i < 52; i++) begin
      rx_a_drv = i < 44 ? bits[i/4] : hold;
      a_if.err_clr = i == clr_at;
      step();
    end
    a_if.err_clr = 1'b0;
  endtask
  task automatic wait_got(input int want);
    int n = 0;
    while (got_a.size() < want && n < 400) begin step(); n++; end
    step(10);
    chk("a_rx_count", 32'(got_a.size()), 32'(want));
  endtask
  task automatic chk_flags_a(input string tag, input logic p, input logic f, input logic o);
    chk({tag, "_parity"}, 32'(a_if.parity_err), 32'(p));
    chk({tag, "_frame"}, 32'(a_if.frame_err), 32'(f));
    chk({tag, "_overrun"}, 32'(a_if.overrun_err), 32'(o));
  endtask
  task automatic pulse_clr_a();
    a_if.err_clr = 1'b1;
    step();
    a_if.err_clr = 1'b0;
  endtask
  initial begin
    a_if.tx_valid = 1'b0; a_if.tx_data = '0; a_if.rx_ready = 1'b0; a_if.err_clr = 1'b0;
    b_if.tx_valid = 1'b0; b_if.tx_data = '0; b_if.rx_ready = 1'b0; b_if.err_clr = 1'b0;
    #1 n_rst = 1'b0;
    #1;
    chk("rst_tx", 32'(tx_a), 1);
    chk("rst_tx_ready", 32'(a_if.tx_ready), 0);
    chk("rst_tx_busy", 32'(a_if.tx_busy), 0);
    chk("rst_rx_valid", 32'(a_if.rx_valid), 0);
    chk("rst_rx_data", 32'(a_if.rx_data), 0);
    chk_flags_a("rst", 1'b0, 1'b0, 1'b0);
    step(2);
    chk("rst_hold_ready", 32'(a_if.tx_ready), 0);
    @(negedge clk) n_rst = 1'b1;
    step();
    chk("ready_first_edge", 32'(a_if.tx_ready), 1);
    // 0xA5 even parity: start, data LSB first, parity 0, stop
    send_a(8'hA5);
    chk_frame("a_tx_a5", 11'b1_0_10100101_0, 1'b0);
    loop_a = 1'b1;
    a_if.rx_ready = 1'b1;
    got_a.delete();
    send_a(8'h00);
    send_a(8'hFF);
    send_a(8'h5A);
    wait_got(3);
    chk("loop_w0", 32'(got_a.size() > 0 ? got_a[0] : 8'hxx), 'h00);
    chk("loop_w1", 32'(got_a.size() > 1 ? got_a[1] : 8'hxx), 'hFF);
    chk("loop_w2", 32'(got_a.size() > 2 ? got_a[2] : 8'hxx), 'h5A);
    chk_flags_a("loop", 1'b0, 1'b0, 1'b0);
    loop_a = 1'b0;
    a_if.rx_ready = 1'b0;
    drive_a(11'b1_1_10100101_0, 1'b1, -1);
    chk("par_rx_valid", 32'(a_if.rx_valid), 1);
    chk("par_rx_data", 32'(a_if.rx_data), 'hA5);
    chk_flags_a("par", 1'b1, 1'b0, 1'b0);
    pulse_clr_a();
    chk("par_cleared", 32'(a_if.parity_err), 0);
    chk("par_valid_kept", 32'(a_if.rx_valid), 1);
    a_if.rx_ready = 1'b1;
    step();
    a_if.rx_ready = 1'b0;
    chk("par_read_clears", 32'(a_if.rx_valid), 0);
    rx_a_drv = 1'b0;
    step();
    rx_a_drv = 1'b1;
    step(20);
    chk("glitch_rx_valid", 32'(a_if.rx_valid), 0);
    chk_flags_a("glitch", 1'b0, 1'b0, 1'b0);
    // err_clr lands on the same edge as the stop sample; the set must win
    drive_a(11'b0_0_00111100_0, 1'b0, 44);
    rx_a_drv = 1'b1;
    step(12);
    chk("frm_rx_valid", 32'(a_if.rx_valid), 0);
    chk_flags_a("frm", 1'b0, 1'b1, 1'b0);
    pulse_clr_a();
    chk("frm_cleared", 32'(a_if.frame_err), 0);
    step(20);
    chk("frm_no_late_word", 32'(a_if.rx_valid), 0);
    loop_a = 1'b1;
    send_a(8'h12);
    send_a(8'h34);
    step(60);
    chk("ovr_rx_valid", 32'(a_if.rx_valid), 1);
    chk("ovr_rx_data_kept", 32'(a_if.rx_data), 'h12);
    chk_flags_a("ovr", 1'b0, 1'b0, 1'b1);
    a_if.rx_ready = 1'b1;
    pulse_clr_a();
    a_if.rx_ready = 1'b0;
    chk("ovr_cleared", 32'(a_if.overrun_err), 0);
    chk("ovr_read", 32'(a_if.rx_valid), 0);
    // 0x41 odd parity over 7 bits gives parity 1, then two stop bits
    send_b(7'h41);
    chk_frame("b_tx_41", 11'b111_1000001_0, 1'b1);
    send_b(7'h22);
    step(60);
    chk("b_rx_valid", 32'(b_if.rx_valid), 1);
    chk("b_rx_data_kept", 32'(b_if.rx_data), 'h41);
    chk("b_overrun", 32'(b_if.overrun_err), 1);
    chk("b_parity", 32'(b_if.parity_err), 0);
    chk("b_frame", 32'(b_if.frame_err), 0);
    got_a.delete();
    a_if.rx_ready = 1'b1;
    send_a(8'h33);
    step(15);
    chk("mid_tx_low", 32'(tx_a), 0);
    n_rst = 1'b0;
    #1;
    chk("mid_rst_tx", 32'(tx_a), 1);
    chk("mid_rst_busy", 32'(a_if.tx_busy), 0);
    chk("mid_rst_ready", 32'(a_if.tx_ready), 0);
    chk("mid_rst_rx_valid", 32'(a_if.rx_valid), 0);
    chk("mid_rst_rx_data", 32'(a_if.rx_data), 0);
    step(3);
    @(negedge clk) n_rst = 1'b1;
    step();
    chk("mid_ready_first_edge", 32'(a_if.tx_ready), 1);
    step(60);
    chk("mid_no_partial", 32'(got_a.size()), 0);
    send_a(8'h96);
    wait_got(1);
    chk("mid_next_word", 32'(got_a.size() > 0 ? got_a[0] : 8'hxx), 'h96);
    chk_flags_a("mid", 1'b0, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
